// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader and the downstream ALU:
// FSM state encoding, 2-bit ALU operation code and the one-hot LED base pattern.
package operand_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2
    } state_t;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_ADD = 2'd0;
    localparam alu_op_t OP_SUB = 2'd1;
    localparam alu_op_t OP_AND = 2'd2;
    localparam alu_op_t OP_OR  = 2'd3;

    localparam logic [3:0] LED_ONEHOT = 4'b0001;

    function automatic logic [3:0] op_led(input alu_op_t op);
        return LED_ONEHOT << op;
    endfunction

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, optional debouncer
// (enabled by OPLOAD_DEBOUNCE_EN) and a one-cycle press pulse on release-to-press.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic nbtn,
    output logic press
);

    logic [1:0] sync;
    logic       level;
    logic       level_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], nbtn};
        end
    end

`ifdef OPLOAD_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          deb;
    logic [CW-1:0] cnt;

    // The debounced level flips only once the synchronized level has disagreed
    // with it for DB_CYCLES consecutive samples; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            deb <= 1'b1;
            cnt <= '0;
        end else if (sync[1] != deb) begin
            if (cnt == LAST) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign level = deb;
`else
    logic unused_db_cycles;
    assign unused_db_cycles = (DB_CYCLES > 0);
    assign level = sync[1];
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            level_d <= 1'b1;
        end else begin
            level_d <= level;
        end
    end

    assign press = level_d & ~level;

endmodule

// File: rtl/operand_loader.sv
// Operand entry front end: two conditioned buttons drive a LOAD_A/LOAD_B/RUN FSM that
// latches vA, vB from the switches and cycles the ALU op code. Macro: OPLOAD_DEBOUNCE_EN.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int Bits      = 5,
    parameter int DB_CYCLES = 16
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            nbtn_next,
    input  logic            nbtn_op,
    input  logic [Bits-1:0] sw,
    output logic [Bits-1:0] vA,
    output logic [Bits-1:0] vB,
    output logic [1:0]      control,
    output logic [3:0]      operation,
    output logic [1:0]      state,
    output logic            valid
);

    logic    next_press;
    logic    op_press;
    state_t  state_q;
    alu_op_t op_inc;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk   (clk),
        .nrst  (nrst),
        .nbtn  (nbtn_next),
        .press (next_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_op (
        .clk   (clk),
        .nrst  (nrst),
        .nbtn  (nbtn_op),
        .press (op_press)
    );

    assign op_inc = control + 2'd1;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= LOAD_A;
            vA        <= '0;
            vB        <= '0;
            control   <= OP_ADD;
            operation <= LED_ONEHOT;
        end else begin
            // NOTE: the default arm recovers the unused encoding and leaves nothing unassigned.
            case (state_q)
                LOAD_A: if (next_press) begin
                    vA      <= sw;
                    state_q <= LOAD_B;
                end
                LOAD_B: if (next_press) begin
                    vB      <= sw;
                    state_q <= RUN;
                end
                RUN: if (next_press) begin
                    state_q <= LOAD_A;
                end
                default: state_q <= LOAD_A;
            endcase

            // Op presses are independent of the entry state and may coincide with a next press.
            if (op_press) begin
                control   <= op_inc;
                operation <= op_led(op_inc);
            end
        end
    end

    assign state = state_q;
    assign valid = (state_q == RUN);

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: presses push expected snapshots, a negedge
// monitor pops and compares whenever the observable output tuple changes.
module tb_operand_loader;

    localparam int BITS = 5;
    localparam int DB   = 16;
`ifdef OPLOAD_DEBOUNCE_EN
    localparam int LAT_MIN = 2 + DB;
    localparam int LAT_MAX = 3 + DB;
`else
    localparam int LAT_MIN = 2;
    localparam int LAT_MAX = 3;
`endif

    logic            clk = 1'b0;
    logic            nrst;
    logic            nbtn_next;
    logic            nbtn_op;
    logic [BITS-1:0] sw;
    logic [BITS-1:0] vA;
    logic [BITS-1:0] vB;
    logic [1:0]      control;
    logic [3:0]      operation;
    logic [1:0]      state;
    logic            valid;

    typedef struct packed {
        logic [1:0]      st;
        logic [BITS-1:0] va;
        logic [BITS-1:0] vb;
        logic [1:0]      ctl;
        logic [3:0]      op;
        logic            vld;
    } snap_t;

    typedef struct {
        snap_t s;
        int    fall;
    } exp_t;

    exp_t  q[$];
    snap_t cur;
    snap_t prev;
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    operand_loader #(.Bits(BITS), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .nbtn_next (nbtn_next),
        .nbtn_op   (nbtn_op),
        .sw        (sw),
        .vA        (vA),
        .vB        (vB),
        .control   (control),
        .operation (operation),
        .state     (state),
        .valid     (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cur = {state, vA, vB, control, operation, valid};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic snap_t mk(input logic [1:0] st, input logic [BITS-1:0] va,
                                 input logic [BITS-1:0] vb, input logic [1:0] ctl,
                                 input logic [3:0] op, input logic vld);
        return {st, va, vb, ctl, op, vld};
    endfunction

    // Monitor: every change of the visible outputs outside reset must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (nrst === 1'b1 && cur !== prev) begin
            if (q.size() == 0) begin
                check("unexpected_change", 32'(cur), 32'(prev));
            end else begin
                e = q.pop_front();
                check("snapshot", 32'(cur), 32'(e.s));
                lat = cyc - e.fall;
                total++;
                if (lat < LAT_MIN || lat > LAT_MAX) begin
                    bad++;
                    $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                end
            end
        end
        prev = cur;
    end

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic press(input logic dn, input logic dop, input snap_t e, input int hold);
        exp_t x;
        @(negedge clk);
        if (dn)  nbtn_next = 1'b0;
        if (dop) nbtn_op   = 1'b0;
        x.s    = e;
        x.fall = cyc;
        q.push_back(x);
        repeat (hold) @(negedge clk);
        nbtn_next = 1'b1;
        nbtn_op   = 1'b1;
        repeat (DB + 8) @(negedge clk);
        drain();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vA"}, 32'(vA), 32'd0);
        check({tag, "_vB"}, 32'(vB), 32'd0);
        check({tag, "_control"}, 32'(control), 32'd0);
        check({tag, "_operation"}, 32'(operation), 32'b0001);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
    endtask

    initial begin
        nrst      = 1'b0;
        nbtn_next = 1'b1;
        nbtn_op   = 1'b1;
        sw        = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        // Load A then B, landing in RUN.
        sw = 5'd9;
        press(1'b1, 1'b0, mk(2'd1, 5'd9, 5'd0, 2'd0, 4'b0001, 1'b0), 25);
        sw = 5'd20;
        press(1'b1, 1'b0, mk(2'd2, 5'd9, 5'd20, 2'd0, 4'b0001, 1'b1), 25);

        // Five op presses walk the code through a full wrap.
        press(1'b0, 1'b1, mk(2'd2, 5'd9, 5'd20, 2'd1, 4'b0010, 1'b1), 25);
        press(1'b0, 1'b1, mk(2'd2, 5'd9, 5'd20, 2'd2, 4'b0100, 1'b1), 25);
        press(1'b0, 1'b1, mk(2'd2, 5'd9, 5'd20, 2'd3, 4'b1000, 1'b1), 25);
        press(1'b0, 1'b1, mk(2'd2, 5'd9, 5'd20, 2'd0, 4'b0001, 1'b1), 25);
        press(1'b0, 1'b1, mk(2'd2, 5'd9, 5'd20, 2'd1, 4'b0010, 1'b1), 25);

        // Next in RUN returns to LOAD_A and keeps the operands and op code.
        sw = 5'd31;
        press(1'b1, 1'b0, mk(2'd0, 5'd9, 5'd20, 2'd1, 4'b0010, 1'b0), 25);

`ifdef OPLOAD_DEBOUNCE_EN
        // A short glitch must be filtered out entirely.
        @(negedge clk);
        nbtn_next = 1'b0;
        repeat (5) @(negedge clk);
        nbtn_next = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_state", 32'(state), 32'd0);
        check("glitch_vA", 32'(vA), 32'd9);
`endif

        // A long hold yields exactly one transition.
        sw = 5'd7;
        press(1'b1, 1'b0, mk(2'd1, 5'd7, 5'd20, 2'd1, 4'b0010, 1'b0), 200);
        check("hold_state", 32'(state), 32'd1);

        // Simultaneous next and op in LOAD_B both land on one edge.
        sw = 5'd12;
        press(1'b1, 1'b1, mk(2'd2, 5'd7, 5'd12, 2'd2, 4'b0100, 1'b1), 25);

        // Reset in RUN with next held: reset wins, then one press after release.
        @(negedge clk);
        nrst      = 1'b0;
        nbtn_next = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst_held");
        begin
            exp_t x;
            sw     = 5'd17;
            x.s    = mk(2'd1, 5'd17, 5'd0, 2'd0, 4'b0001, 1'b0);
            x.fall = cyc;
            q.push_back(x);
            nrst = 1'b1;
        end
        repeat (40) @(negedge clk);
        nbtn_next = 1'b1;
        repeat (DB + 8) @(negedge clk);
        drain();
        check("post_reset_state", 32'(state), 32'd1);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
